// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and instruction memory.
//   imem_req   : read request, held until imem_ready is seen
//   imem_addr  : word address of the request
//   imem_rdata : read data, valid when imem_ready is high
//   imem_ready : read data valid this cycle
// master = fetch unit side, slave = memory side.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic                imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the multicycle CPU. Owns the program counter,
// reads one instruction word per fetch phase over the imem channel and
// latches it for decode. PC redirects are accepted in any FSM state.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   state       : global sequencer state, 0 = fetch
//   pc_load     : redirect strobe, pc <= pc_target
//   pc_target   : redirect address
//   imem        : instruction-memory channel (fetch_unit_if.master)
//   instruction : latched instruction word
//   pc          : current program counter
//   fetch_done  : one-cycle pulse when instruction is updated
//   busy        : high while waiting on memory
//   fetch_fault : sticky fetch-timeout flag
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   Defined   : a WAIT that sees no imem_ready for TIMEOUT cycles ends with a
//               NOP, sets fetch_fault and leaves pc untouched.
//   Undefined : WAIT lasts until imem_ready; fetch_fault is tied 0.
//
// state | meaning
// IDLE  | no request outstanding, waiting for sequencer fetch state
// WAIT  | request issued, waiting for imem_ready
// DONE  | instruction latched, waiting for sequencer to leave fetch
module fetch_unit #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          state,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_target,
    fetch_unit_if.master        imem,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_done,
    output logic                busy,
    output logic                fetch_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t fsm;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Down-counter: loaded with TIMEOUT-1 on WAIT entry, so terminal count
    // (zero) with no ready marks the TIMEOUT-th WAIT cycle without data.
    logic [TW-1:0] wait_cnt;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm            <= IDLE;
            pc             <= PC_WIDTH'(RESET_PC);
            instruction    <= 32'h0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
            fetch_done     <= 1'b0;
            busy           <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_fault    <= 1'b0;
            wait_cnt       <= '0;
`endif
        end else begin
            fetch_done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (state == 3'd0) begin
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc;
                        busy           <= 1'b1;
                        fsm            <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt       <= TW'(TIMEOUT - 1);
`endif
                    end
                end
                WAIT: begin
                    if (imem.imem_ready) begin
                        instruction   <= imem.imem_rdata;
                        pc            <= pc + 1'b1;
                        imem.imem_req <= 1'b0;
                        busy          <= 1'b0;
                        fetch_done    <= 1'b1;
                        fsm           <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt == '0) begin
                        instruction   <= 32'h0000_0000;
                        fetch_fault   <= 1'b1;
                        imem.imem_req <= 1'b0;
                        busy          <= 1'b0;
                        fetch_done    <= 1'b1;
                        fsm           <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                DONE: begin
                    // Dwell here while the sequencer stays in fetch so the
                    // same phase never issues a second read.
                    if (state != 3'd0) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
            // Redirect beats the increment on a completing edge; the
            // in-flight read still finishes against the old address.
            if (pc_load) begin
                pc <= pc_target;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int PC_WIDTH = 8;
    localparam int TIMEOUT  = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [2:0]          state;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_target;
    logic [31:0]         instruction;
    logic [PC_WIDTH-1:0] pc;
    logic                fetch_done;
    logic                busy;
    logic                fetch_fault;

    int checks   = 0;
    int failures = 0;

    fetch_unit_if #(.PC_WIDTH(PC_WIDTH)) imem_bus ();

    fetch_unit #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .imem        (imem_bus),
        .instruction (instruction),
        .pc          (pc),
        .fetch_done  (fetch_done),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  done_pulses;
    int  req_seen;
    int  unstable;

    initial begin
        reset     = 1'b1;
        state     = 3'd7;
        pc_load   = 1'b0;
        pc_target = '0;
        imem_bus.imem_rdata = 32'h0;
        imem_bus.imem_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pc",    32'(pc), 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_req",   32'(imem_bus.imem_req), 32'h0);
        check("rst_addr",  32'(imem_bus.imem_addr), 32'h0);
        check("rst_done",  32'(fetch_done), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_fault", 32'(fetch_fault), 32'h0);

        // Zero-wait fetch from address 0
        reset = 1'b0;
        state = 3'd0;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h8C22_0004;
        tick();
        check("zw_req",   32'(imem_bus.imem_req), 32'h1);
        check("zw_addr",  32'(imem_bus.imem_addr), 32'h0);
        check("zw_busy",  32'(busy), 32'h1);
        check("zw_done0", 32'(fetch_done), 32'h0);
        tick();
        check("zw_instr", instruction, 32'h8C22_0004);
        check("zw_pc",    32'(pc), 32'h1);
        check("zw_done1", 32'(fetch_done), 32'h1);
        check("zw_req0",  32'(imem_bus.imem_req), 32'h0);
        done_pulses = 0;
        req_seen    = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fetch_done) done_pulses++;
            if (imem_bus.imem_req) req_seen++;
        end
        check("zw_no_refetch", 32'(req_seen), 32'h0);
        check("zw_no_redone",  32'(done_pulses), 32'h0);

        // Memory delays ready by 5 cycles; sequencer leaves fetch mid-wait
        state = 3'd3;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        state = 3'd0;
        tick();
        state = 3'd1;
        unstable    = 0;
        done_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 8'h01 || busy !== 1'b1)
                unstable++;
            if (fetch_done) done_pulses++;
            tick();
        end
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 8'h01 || busy !== 1'b1)
            unstable++;
        check("dly_stable",     32'(unstable), 32'h0);
        check("dly_early_done", 32'(done_pulses), 32'h0);
        check("dly_pc_hold",    32'(pc), 32'h1);
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        check("dly_instr", instruction, 32'hDEAD_BEEF);
        check("dly_pc",    32'(pc), 32'h2);
        check("dly_done",  32'(fetch_done), 32'h1);
        check("dly_busy",  32'(busy), 32'h0);
        tick();
        check("dly_done_pulse", 32'(fetch_done), 32'h0);

        // PC wrap from 0xFF
        pc_load   = 1'b1;
        pc_target = 8'hFF;
        tick();
        pc_load = 1'b0;
        check("wrap_load", 32'(pc), 32'hFF);
        state = 3'd0;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h1111_1111;
        tick();
        check("wrap_addr", 32'(imem_bus.imem_addr), 32'hFF);
        tick();
        check("wrap_pc",    32'(pc), 32'h00);
        check("wrap_instr", instruction, 32'h1111_1111);
        state = 3'd1;
        imem_bus.imem_ready = 1'b0;
        tick();

        // Redirect on the completing edge of a fetch from 0x10
        pc_load   = 1'b1;
        pc_target = 8'h10;
        tick();
        pc_load = 1'b0;
        state   = 3'd0;
        tick();
        check("redir_addr", 32'(imem_bus.imem_addr), 32'h10);
        state = 3'd1;
        imem_bus.imem_rdata = 32'hA5A5_0010;
        imem_bus.imem_ready = 1'b1;
        pc_load   = 1'b1;
        pc_target = 8'h40;
        tick();
        pc_load = 1'b0;
        imem_bus.imem_ready = 1'b0;
        check("redir_instr", instruction, 32'hA5A5_0010);
        check("redir_pc",    32'(pc), 32'h40);
        check("redir_done",  32'(fetch_done), 32'h1);
        tick();
        state = 3'd0;
        tick();
        check("redir_next_req",  32'(imem_bus.imem_req), 32'h1);
        check("redir_next_addr", 32'(imem_bus.imem_addr), 32'h40);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h0000_0040;
        tick();
        check("redir_next_pc", 32'(pc), 32'h41);
        imem_bus.imem_ready = 1'b0;
        state = 3'd1;
        tick();

`ifdef FETCH_TIMEOUT_EN
        // Timeout: ready never arrives
        state = 3'd0;
        tick();
        done_pulses = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (fetch_done) done_pulses++;
        end
        check("to_early_done", 32'(done_pulses), 32'h0);
        check("to_fault_early", 32'(fetch_fault), 32'h0);
        tick();
        check("to_done",  32'(fetch_done), 32'h1);
        check("to_fault", 32'(fetch_fault), 32'h1);
        check("to_instr", instruction, 32'h0);
        check("to_pc",    32'(pc), 32'h41);
        check("to_req",   32'(imem_bus.imem_req), 32'h0);
        state = 3'd1;
        tick();
        tick();
        check("to_sticky", 32'(fetch_fault), 32'h1);
`endif

        // Reset while in WAIT, then a late ready
        state = 3'd0;
        tick();
        check("rw_req_pre", 32'(imem_bus.imem_req), 32'h1);
        reset = 1'b1;
        tick();
        check("rw_req",   32'(imem_bus.imem_req), 32'h0);
        check("rw_pc",    32'(pc), 32'h0);
        check("rw_done",  32'(fetch_done), 32'h0);
        check("rw_busy",  32'(busy), 32'h0);
        check("rw_fault", 32'(fetch_fault), 32'h0);
        reset = 1'b0;
        state = 3'd1;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hBAD0_BAD0;
        tick();
        check("rw_late_done",  32'(fetch_done), 32'h0);
        check("rw_late_instr", instruction, 32'h0);
        check("rw_late_pc",    32'(pc), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
